pop_delay_vc_arb: RTL and testbench

POP_DELAY_VC_ARB -- requirements
Module: pop_delay_vc_arb

---
 rtl/pop_delay_vc_arb.sv | 124 ++++++++++++
 tb/tb_pop_delay_vc_arb.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pop_delay_vc_arb.sv
// Pop arbiter that picks one non-empty VC FIFO per cycle when every destination has room.
// Define POP_STARVE_GUARD_EN to add a starvation guard that occasionally lets the highest eligible VC win.

module pop_delay_vc_lane (
  input  logic clk,
  input  logic reset,
  input  logic vc_empty,
  input  logic dest_ok,
  input  logic gnt,
  output logic elig,
  output logic pop
);

  // A VC that popped last cycle must sit out one cycle before it can pop again.
  assign elig = !vc_empty && dest_ok && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pop <= 1'b0;
    else       pop <= gnt;
  end

endmodule

module pop_delay_vc_arb #(
  parameter int NUM_VC       = 2,
  parameter int NUM_DEST     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_VC-1:0]         vc_empty,
  input  logic [NUM_DEST-1:0]       d_full,
  output logic [NUM_VC-1:0]         vc_pop,
  output logic                      pop_valid,
  output logic [$clog2(NUM_VC)-1:0] pop_vc_id,
  output logic [3:0]                starve_cnt
);

  localparam int ID_W = $clog2(NUM_VC);

  if (NUM_VC < 2 || NUM_VC > 4 || NUM_DEST < 1 || NUM_DEST > 4 ||
      STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_cfg
    $error("pop_delay_vc_arb: parameter out of range");
  end

  logic              dest_ok;
  logic [NUM_VC-1:0] elig;
  logic [NUM_VC-1:0] lo_oh;
  logic [NUM_VC-1:0] gnt;
  logic [ID_W-1:0]   pop_enc;

  assign dest_ok = ~|d_full;

  // Two's complement trick isolates the lowest set bit: the default priority winner.
  assign lo_oh = elig & (~elig + NUM_VC'(1));

  for (genvar g = 0; g < NUM_VC; g++) begin : g_lane
    pop_delay_vc_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .vc_empty (vc_empty[g]),
      .dest_ok  (dest_ok),
      .gnt      (gnt[g]),
      .elig     (elig[g]),
      .pop      (vc_pop[g])
    );
  end

`ifdef POP_STARVE_GUARD_EN
  logic [NUM_VC-1:0] hi_oh;
  logic              multi;
  logic              force_hi;
  logic [3:0]        starve_d;

  // Any eligible bit besides the lowest means a higher-index VC loses this round.
  assign multi = |(elig & ~lo_oh);

  always_comb begin
    hi_oh = '0;
    for (int i = 0; i < NUM_VC; i++)
      if (elig[i]) begin
        hi_oh    = '0;
        hi_oh[i] = 1'b1;
      end
  end

  always_comb begin
    force_hi = (starve_cnt == 4'(STARVE_LIMIT)) && multi;
    gnt      = force_hi ? hi_oh : lo_oh;
    starve_d = starve_cnt;
    if (force_hi)
      starve_d = '0;
    else if (multi)
      starve_d = (starve_cnt >= 4'(STARVE_LIMIT)) ? 4'(STARVE_LIMIT) : starve_cnt + 4'd1;
    else if (|elig)
      starve_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt <= '0;
    else       starve_cnt <= starve_d;
  end
`else
  assign gnt        = lo_oh;
  assign starve_cnt = '0;
`endif

  always_comb begin
    pop_enc = '0;
    for (int i = 0; i < NUM_VC; i++)
      if (vc_pop[i]) pop_enc = ID_W'(i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_valid <= 1'b0;
      pop_vc_id <= '0;
    end else begin
      pop_valid <= |vc_pop;
      if (|vc_pop) pop_vc_id <= pop_enc;
    end
  end

endmodule

// File: tb/tb_pop_delay_vc_arb.sv
// Directed bench for pop_delay_vc_arb (2 VCs, 2 destinations, starve limit 3).
// Expected starvation behaviour follows whether POP_STARVE_GUARD_EN is defined.

module tb_pop_delay_vc_arb;

`ifdef POP_STARVE_GUARD_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] vc_empty;
  logic [1:0] d_full;
  logic [1:0] vc_pop;
  logic       pop_valid;
  logic [0:0] pop_vc_id;
  logic [3:0] starve_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pop_delay_vc_arb #(.NUM_VC(2), .NUM_DEST(2), .STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .vc_empty   (vc_empty),
    .d_full     (d_full),
    .vc_pop     (vc_pop),
    .pop_valid  (pop_valid),
    .pop_vc_id  (pop_vc_id),
    .starve_cnt (starve_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] p, input logic v,
                         input logic i, input int c);
    chk({tag, ".pop"}, 8'(vc_pop), 8'(p));
    chk({tag, ".pv"},  8'(pop_valid), 8'(v));
    chk({tag, ".id"},  8'(pop_vc_id), 8'(i));
    chk({tag, ".cnt"}, 8'(starve_cnt), 8'(c));
  endtask

  // Drive inputs, let one edge sample them, then look 1ns after the edge.
  task automatic tick(input logic [1:0] ve, input logic [1:0] df);
    vc_empty = ve;
    d_full   = df;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    vc_empty = 2'b00;
    d_full   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst", 2'b00, 1'b0, 1'b0, 0);
    reset = 1'b0;

    // Both VCs full of data: strict alternation through the back-to-back rule.
    tick(2'b00, 2'b00); chk_all("e1",  2'b01, 1'b0, 1'b0, G);
    tick(2'b00, 2'b00); chk_all("e2",  2'b10, 1'b1, 1'b0, 0);
    tick(2'b00, 2'b00); chk_all("e3",  2'b01, 1'b1, 1'b1, 0);

    // Build up starvation by hiding VC1 on VC0's cool-down cycles.
    tick(2'b10, 2'b00); chk_all("e4",  2'b00, 1'b1, 1'b0, 0);
    tick(2'b00, 2'b00); chk_all("e5",  2'b01, 1'b0, 1'b0, G);
    tick(2'b10, 2'b00); chk_all("e6",  2'b00, 1'b1, 1'b0, G);

    // Blocked destinations: no pop and the counter holds.
    tick(2'b00, 2'b01); chk_all("df01", 2'b00, 1'b0, 1'b0, G);
    tick(2'b00, 2'b10); chk_all("df10", 2'b00, 1'b0, 1'b0, G);
    tick(2'b00, 2'b11); chk_all("df11", 2'b00, 1'b0, 1'b0, G);

    tick(2'b00, 2'b00); chk_all("e10", 2'b01, 1'b0, 1'b0, 2*G);
    tick(2'b10, 2'b00); chk_all("e11", 2'b00, 1'b1, 1'b0, 2*G);
    tick(2'b00, 2'b00); chk_all("e12", 2'b01, 1'b0, 1'b0, 3*G);
    tick(2'b10, 2'b00); chk_all("e13", 2'b00, 1'b1, 1'b0, 3*G);

    // At the limit the guard hands the grant to VC1 and clears.
    tick(2'b00, 2'b00); chk_all("force", G ? 2'b10 : 2'b01, 1'b0, 1'b0, 0);
    tick(2'b00, 2'b00); chk_all("e15", G ? 2'b01 : 2'b10, 1'b1, G ? 1'b1 : 1'b0, 0);

    // Only VC0 has data: pops every other cycle.
    tick(2'b11, 2'b00); chk_all("e16", 2'b00, 1'b1, G ? 1'b0 : 1'b1, 0);
    tick(2'b10, 2'b00); chk_all("alt1", 2'b01, 1'b0, G ? 1'b0 : 1'b1, 0);
    tick(2'b10, 2'b00); chk_all("alt2", 2'b00, 1'b1, 1'b0, 0);
    tick(2'b10, 2'b00); chk_all("alt3", 2'b01, 1'b0, 1'b0, 0);
    tick(2'b10, 2'b00); chk_all("alt4", 2'b00, 1'b1, 1'b0, 0);

    // A destination filling up during a pop must not cancel it.
    tick(2'b00, 2'b00); chk_all("e21", 2'b01, 1'b0, 1'b0, G);
    tick(2'b00, 2'b01); chk_all("dfpop", 2'b00, 1'b1, 1'b0, G);

    tick(2'b00, 2'b00); chk_all("e23", 2'b01, 1'b0, 1'b0, 2*G);
    tick(2'b00, 2'b00); chk_all("e24", 2'b10, 1'b1, 1'b0, 0);
    tick(2'b00, 2'b00); chk_all("e25", 2'b01, 1'b1, 1'b1, 0);

    // Asynchronous reset between edges clears everything immediately.
    #3 reset = 1'b1;
    #1 chk_all("arst", 2'b00, 1'b0, 1'b0, 0);
    vc_empty = 2'b11;
    @(posedge clk); #1;
    chk_all("arst_hold", 2'b00, 1'b0, 1'b0, 0);
    reset = 1'b0;
    tick(2'b11, 2'b00); chk_all("post_rst", 2'b00, 1'b0, 1'b0, 0);
    tick(2'b00, 2'b00); chk_all("post_pop", 2'b01, 1'b0, 1'b0, G);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
